// File: rtl/mux2_rr_feeder_pkg.sv
// Shared definitions for the round-robin feeder of the 2:1 output mux.
package mux2_rr_feeder_pkg;

  typedef enum logic {
    LAST_B = 1'b0,
    LAST_A = 1'b1
  } last_e;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  // Tie-break: grant the channel that was not served most recently.
  function automatic logic tie_pick(input last_e last);
    return (last == LAST_A) ? SEL_B : SEL_A;
  endfunction

endpackage

// File: rtl/mux2_rr_feeder_chan_buf.sv
// One-entry valid/ready buffer; a drain and a refill may happen in the same cycle.
module chan_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             drain_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;

  assign ready_o = !full_q || drain_i;
  assign accept  = valid_i && ready_o;
  assign data_o  = data_q;
  assign full_o  = full_q;

  // A drained word leaves its data in place; only the full flag clears.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/mux2_rr_feeder.sv
// Two buffered input channels feeding a 2:1 mux, with round-robin select
// that is frozen while the downstream stalls.
module mux2_rr_feeder
  import mux2_rr_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic  a_full, b_full;
  logic  sel_q, hold_q, hold_d;
  last_e last_q, last_d;
  logic  out_xfer;
  logic  drain_a, drain_b;

  assign out_xfer = out_valid && out_ready;
  assign drain_a  = out_xfer && (sel == SEL_A);
  assign drain_b  = out_xfer && (sel == SEL_B);

  chan_buf #(.WIDTH(WIDTH)) u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (a_in),
    .valid_i (a_valid),
    .ready_o (a_ready),
    .drain_i (drain_a),
    .data_o  (a_q),
    .full_o  (a_full)
  );

  chan_buf #(.WIDTH(WIDTH)) u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (b_in),
    .valid_i (b_valid),
    .ready_o (b_ready),
    .drain_i (drain_b),
    .data_o  (b_q),
    .full_o  (b_full)
  );

  // Select is derived only from registered state, so ready paths stay loop-free.
  always_comb begin
    sel = sel_q;
    if (hold_q) begin
      sel = sel_q;
    end else if (a_full && b_full) begin
      sel = tie_pick(last_q);
    end else if (a_full) begin
      sel = SEL_A;
    end else if (b_full) begin
      sel = SEL_B;
    end
  end

  assign out_valid = (sel == SEL_A) ? a_full : b_full;

  always_comb begin
    hold_d = out_valid && !out_ready;
    last_d = last_q;
    if (out_xfer) begin
      last_d = (sel == SEL_A) ? LAST_A : LAST_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= SEL_B;
      hold_q <= 1'b0;
      last_q <= LAST_B;
    end else begin
      sel_q  <= sel;
      hold_q <= hold_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_mux2_rr_feeder.sv
// Directed bench for mux2_rr_feeder: reset, single channel, ties, stall, streaming, mid-op reset.
module tb_mux2_rr_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_in, b_in;
  logic       a_valid, b_valid, out_ready;
  logic       a_ready, b_ready, sel, out_valid;
  logic [7:0] a_q, b_q;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mux2_rr_feeder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_in      (b_in),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .a_q       (a_q),
    .b_q       (b_q),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset with valids asserted
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_in = 8'hFF; b_in = 8'hEE; out_ready = 1'b1;
    #3;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_a_q", a_q, 8'h00);
    chk("rst_b_q", b_q, 8'h00);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // 2: A only, one-cycle latency, stale data after drain
    tick();
    a_in = 8'h3C; a_valid = 1'b1; out_ready = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("aonly_valid", out_valid, 1);
    chk("aonly_sel", sel, 1);
    chk("aonly_a_q", a_q, 8'h3C);
    tick();
    chk("aonly_empty", out_valid, 0);
    chk("aonly_stale", a_q, 8'h3C);

    // 3: tie from a fresh arbiter, then continuous alternation
    pulse_reset();
    tick();
    a_in = 8'hAA; b_in = 8'h55; a_valid = 1'b1; b_valid = 1'b1;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("tie1_sel", sel, 1);
    chk("tie1_valid", out_valid, 1);
    chk("tie1_a_q", a_q, 8'hAA);
    chk("tie1_b_ready", b_ready, 0);
    tick();
    chk("tie2_sel", sel, 0);
    chk("tie2_valid", out_valid, 1);
    chk("tie2_b_q", b_q, 8'h55);
    tick();
    chk("tie_empty", out_valid, 0);
    a_in = 8'h10; b_in = 8'h20; a_valid = 1'b1; b_valid = 1'b1;
    tick();
    chk("alt0_sel", sel, 1);
    chk("alt0_a_ready", a_ready, 1);
    chk("alt0_b_ready", b_ready, 0);
    tick();
    chk("alt1_sel", sel, 0);
    chk("alt1_a_ready", a_ready, 0);
    chk("alt1_b_q", b_q, 8'h20);
    tick();
    chk("alt2_sel", sel, 1);
    tick();
    chk("alt3_sel", sel, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    tick();
    chk("alt_flushed", out_valid, 0);

    // 4: stall; A filling later must not steal the grant
    pulse_reset();
    tick();
    out_ready = 1'b0; b_in = 8'h5A; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("stall_c1_sel", sel, 0);
    chk("stall_c1_valid", out_valid, 1);
    chk("stall_c1_b_q", b_q, 8'h5A);
    a_in = 8'hC3; a_valid = 1'b1;
    chk("stall_a_ready_empty", a_ready, 1);
    tick();
    a_valid = 1'b0;
    chk("stall_c2_sel", sel, 0);
    chk("stall_a_ready_full", a_ready, 0);
    chk("stall_b_ready", b_ready, 0);
    for (int i = 3; i <= 5; i++) begin
      chk("stall_sel", sel, 0);
      chk("stall_b_q", b_q, 8'h5A);
      chk("stall_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    chk("stall_release_sel", sel, 0);
    tick();
    chk("stall_then_a_sel", sel, 1);
    chk("stall_then_a_q", a_q, 8'hC3);
    chk("stall_then_a_valid", out_valid, 1);
    tick();
    chk("stall_empty", out_valid, 0);

    // 5: streaming on A at full rate
    a_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in = i[7:0];
      chk("stream_a_ready", a_ready, 1);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_sel", sel, 1);
      chk("stream_a_q", a_q, i);
    end
    a_valid = 1'b0;
    tick();
    chk("stream_empty", out_valid, 0);

    // 6: reset pulse between edges with both buffers full
    out_ready = 1'b0; a_in = 8'h77; b_in = 8'h88; a_valid = 1'b1; b_valid = 1'b1;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("mid_full_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_a_q", a_q, 8'h00);
    chk("mid_rst_b_q", b_q, 8'h00);
    chk("mid_rst_a_ready", a_ready, 1);
    rst_n = 1'b1;
    out_ready = 1'b1; a_in = 8'h11; b_in = 8'h22; a_valid = 1'b1; b_valid = 1'b1;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("post_tie_sel", sel, 1);
    chk("post_tie_a_q", a_q, 8'h11);
    tick();
    chk("post_tie2_sel", sel, 0);
    chk("post_tie2_b_q", b_q, 8'h22);
    tick();
    chk("post_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
